// File: rtl/instr_mem_server_pkg.sv
// Shared constants and types for the instruction-memory server and its RAM.
package instr_mem_server_pkg;

    // Instruction word and fetch address geometry
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned AW_DEF  = 12;

    // Word returned for fetches beyond the implemented depth
    localparam logic [INSTR_W-1:0] FILL_WORD_DEF = 16'h0000;

    // Opcode field position, shared with the decoder
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;

    // Server control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    // Even-parity bit: makes the total number of ones (data + bit) even
    function automatic logic even_parity(input logic [INSTR_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/instr_ram.sv
// Single-port synchronous RAM with registered read; contents are never reset.
module instr_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IW    = 8,
    parameter int unsigned W     = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [IW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write on we, registered read on re; read data holds otherwise
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/instr_mem_server.sv
// Instruction-memory server: latency-1 fetch port plus sequential program-load port.
// Optional even-parity protection is enabled by defining INSTR_PARITY_EN.
module instr_mem_server
    import instr_mem_server_pkg::*;
#(
    parameter int unsigned        DEPTH     = 256,
    parameter int unsigned        AW        = AW_DEF,
    parameter logic [INSTR_W-1:0] FILL_WORD = FILL_WORD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_req,
    input  logic [AW-1:0]      fetch_addr,
    output logic               fetch_busy,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_done,
    output logic [AW-1:0]      load_count,
`ifdef INSTR_PARITY_EN
    output logic               parity_err,
`endif
    output logic               oob_err
);

    // Counter is one bit wider than the address so it can hold DEPTH itself
    localparam int unsigned    CW      = AW + 1;
    localparam int unsigned    IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
`ifdef INSTR_PARITY_EN
    localparam int unsigned    RW      = INSTR_W + 1;
`else
    localparam int unsigned    RW      = INSTR_W;
`endif

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            fill_q, fill_d;
    logic            oob_q, oob_d;

    logic            ram_we, ram_re;
    logic [IW-1:0]   ram_addr;
    logic [RW-1:0]   ram_wdata, ram_rdata;

`ifdef INSTR_PARITY_EN
    assign ram_wdata = {even_parity(load_data), load_data};
`else
    assign ram_wdata = load_data;
`endif

    // Next-state, counter, RAM port arbitration and sticky error
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        fill_d   = fill_q;
        oob_d    = oob_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = fetch_addr[IW-1:0];
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    // load wins over a simultaneous fetch, which is dropped
                    state_d = LOAD;
                    cnt_d   = '0;
                end else if (fetch_req) begin
                    valid_d = 1'b1;
                    if ({1'b0, fetch_addr} >= DEPTH_C) begin
                        fill_d = 1'b1;
                        oob_d  = 1'b1;
                    end else begin
                        fill_d = 1'b0;
                        ram_re = 1'b1;
                    end
                end
            end
            LOAD: begin
                ram_addr = cnt_q[IW-1:0];
                if (load_start) begin
                    cnt_d = '0;
                end else if (load_valid) begin
                    if (cnt_q < DEPTH_C) begin
                        ram_we = 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                    end else begin
                        oob_d = 1'b1;
                    end
                    if (load_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and control registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            fill_q  <= 1'b1;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            fill_q  <= fill_d;
            oob_q   <= oob_d;
        end
    end

    instr_ram #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .W     (RW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // fill_q resets high so instr shows FILL_WORD before any fetch
    assign instr       = fill_q ? FILL_WORD : ram_rdata[INSTR_W-1:0];
    assign instr_valid = valid_q;
    assign fetch_busy  = (state_q != IDLE);
    assign load_done   = (state_q == DONE);
    // At DEPTH=4096 the saturated count does not fit AW bits and reads as 0
    assign load_count  = cnt_q[AW-1:0];
    assign oob_err     = oob_q;

`ifdef INSTR_PARITY_EN
    assign parity_err  = valid_q && !fill_q &&
                         (even_parity(ram_rdata[INSTR_W-1:0]) != ram_rdata[INSTR_W]);
`endif

endmodule

// File: tb/tb_instr_mem_server.sv
// Testbench for instr_mem_server: fetch scoreboard on the default-depth instance,
// load-overflow scenario on a DEPTH=4 instance.
module tb_instr_mem_server;

    logic        clk = 1'b0;
    logic        rst;

    // Main instance (DEPTH=256)
    logic        fetch_req, fetch_busy, instr_valid;
    logic [11:0] fetch_addr, load_count;
    logic [15:0] instr, load_data;
    logic        load_start, load_valid, load_last, load_done, oob_err;

    // Small instance (DEPTH=4)
    logic        s_fetch_req, s_fetch_busy, s_instr_valid;
    logic [11:0] s_fetch_addr, s_load_count;
    logic [15:0] s_instr, s_load_data;
    logic        s_load_start, s_load_valid, s_load_last, s_load_done, s_oob_err;

`ifdef INSTR_PARITY_EN
    logic        parity_err, s_parity_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [15:0] model [256];

    always #5 clk = ~clk;

    instr_mem_server #(.DEPTH(256), .AW(12), .FILL_WORD(16'h0000)) u_dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_busy(fetch_busy),
        .instr(instr), .instr_valid(instr_valid),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_done(load_done), .load_count(load_count),
`ifdef INSTR_PARITY_EN
        .parity_err(parity_err),
`endif
        .oob_err(oob_err)
    );

    instr_mem_server #(.DEPTH(4), .AW(12), .FILL_WORD(16'h0000)) u_small (
        .clk(clk), .rst(rst),
        .fetch_req(s_fetch_req), .fetch_addr(s_fetch_addr), .fetch_busy(s_fetch_busy),
        .instr(s_instr), .instr_valid(s_instr_valid),
        .load_start(s_load_start), .load_valid(s_load_valid), .load_data(s_load_data),
        .load_last(s_load_last), .load_done(s_load_done), .load_count(s_load_count),
`ifdef INSTR_PARITY_EN
        .parity_err(s_parity_err),
`endif
        .oob_err(s_oob_err)
    );

    // Scoreboard monitor: every instr_valid on the main instance pops one expectation
    always @(negedge clk) begin
        if (!rst && instr_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_valid: instr_valid=1 instr=%h, no fetch outstanding", instr);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (instr !== e) begin
                    errors++;
                    $display("FAIL sb_instr: got %h expected %h", instr, e);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        fetch_req = 0; fetch_addr = '0; load_start = 0; load_valid = 0; load_data = '0; load_last = 0;
        s_fetch_req = 0; s_fetch_addr = '0; s_load_start = 0; s_load_valid = 0; s_load_data = '0; s_load_last = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (instr !== 16'h0000 || instr_valid !== 1'b0 || fetch_busy !== 1'b0 ||
            load_done !== 1'b0 || load_count !== 12'd0 || oob_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: instr=%h valid=%b busy=%b done=%b count=%0d oob=%b expected 0000 0 0 0 0 0",
                     instr, instr_valid, fetch_busy, load_done, load_count, oob_err);
        end
        checks++;
        if (s_fetch_busy !== 1'b0 || s_load_count !== 12'd0 || s_oob_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_small: busy=%b count=%0d oob=%b expected 0 0 0", s_fetch_busy, s_load_count, s_oob_err);
        end
    endtask

    task automatic test_program_load();
        logic [15:0] w [4];
        w[0] = 16'h0208; w[1] = 16'h0000; w[2] = 16'h0203; w[3] = 16'h0209;
        @(posedge clk); #1 load_start = 1;
        @(posedge clk); #1 load_start = 0;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1; load_data = w[i]; load_last = (i == 3);
            model[i] = w[i];
            @(negedge clk);
            checks++;
            if (fetch_busy !== 1'b1) begin
                errors++;
                $display("FAIL load_busy[%0d]: fetch_busy=%b expected 1", i, fetch_busy);
            end
            @(posedge clk); #1;
        end
        load_valid = 0; load_last = 0;
        @(negedge clk);
        checks++;
        if (load_done !== 1'b1 || fetch_busy !== 1'b1 || load_count !== 12'd4) begin
            errors++;
            $display("FAIL load_done_pulse: done=%b busy=%b count=%0d expected 1 1 4", load_done, fetch_busy, load_count);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (load_done !== 1'b0 || fetch_busy !== 1'b0 || load_count !== 12'd4) begin
            errors++;
            $display("FAIL load_after_done: done=%b busy=%b count=%0d expected 0 0 4", load_done, fetch_busy, load_count);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 fetch_req = 1; fetch_addr = 12'(i);
            exp_q.push_back(model[i]);
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (instr_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_valid[%0d]: instr_valid=%b expected 1", i - 1, instr_valid);
                end
            end
        end
        @(posedge clk); #1 fetch_req = 0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_valid[3]: instr_valid=%b expected 1", instr_valid);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_valid_end: instr_valid=%b expected 0", instr_valid);
        end
    endtask

    task automatic test_collision();
        @(posedge clk); #1 fetch_req = 1; fetch_addr = 12'd2; load_start = 1;
        @(posedge clk); #1 fetch_req = 0; load_start = 0;
        @(negedge clk);
        checks++;
        if (fetch_busy !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL collision: busy=%b valid=%b expected 1 0", fetch_busy, instr_valid);
        end
        load_valid = 1; load_data = 16'h0208; load_last = 1;
        model[0] = 16'h0208;
        @(posedge clk); #1 load_valid = 0; load_last = 0;
        @(negedge clk);
        checks++;
        if (load_done !== 1'b1 || load_count !== 12'd1) begin
            errors++;
            $display("FAIL collision_load: done=%b count=%0d expected 1 1", load_done, load_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_oob_fetch();
        @(posedge clk); #1 fetch_req = 1; fetch_addr = 12'h100;
        exp_q.push_back(16'h0000);
        @(posedge clk); #1 fetch_addr = 12'd3;
        exp_q.push_back(model[3]);
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || oob_err !== 1'b1) begin
            errors++;
            $display("FAIL oob_fetch: valid=%b oob=%b expected 1 1", instr_valid, oob_err);
        end
        @(posedge clk); #1 fetch_req = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (oob_err !== 1'b1) begin
            errors++;
            $display("FAIL oob_sticky: oob=%b expected 1", oob_err);
        end
    endtask

    task automatic test_load_overflow();
        logic [15:0] w [6];
        for (int i = 0; i < 6; i++) w[i] = 16'hA001 + 16'(i);
        @(posedge clk); #1 s_load_start = 1;
        @(posedge clk); #1 s_load_start = 0;
        for (int i = 0; i < 6; i++) begin
            s_load_valid = 1; s_load_data = w[i]; s_load_last = (i == 5);
            @(negedge clk);
            if (i == 4) begin
                checks++;
                if (s_load_count !== 12'd4 || s_oob_err !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_at_depth: count=%0d oob=%b expected 4 0", s_load_count, s_oob_err);
                end
            end
            @(posedge clk); #1;
        end
        s_load_valid = 0; s_load_last = 0;
        @(negedge clk);
        checks++;
        if (s_load_done !== 1'b1 || s_load_count !== 12'd4 || s_oob_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_done: done=%b count=%0d oob=%b expected 1 4 1", s_load_done, s_load_count, s_oob_err);
        end
        @(posedge clk); #1 s_fetch_req = 1; s_fetch_addr = 12'd0;
        @(posedge clk); #1 s_fetch_addr = 12'd3;
        @(negedge clk);
        checks++;
        if (s_instr_valid !== 1'b1 || s_instr !== 16'hA001) begin
            errors++;
            $display("FAIL ovf_addr0: valid=%b instr=%h expected 1 a001", s_instr_valid, s_instr);
        end
        @(posedge clk); #1 s_fetch_req = 0;
        @(negedge clk);
        checks++;
        if (s_instr_valid !== 1'b1 || s_instr !== 16'hA004) begin
            errors++;
            $display("FAIL ovf_addr3: valid=%b instr=%h expected 1 a004", s_instr_valid, s_instr);
        end
    endtask

    task automatic test_reset_mid_load();
        @(posedge clk); #1 load_start = 1;
        @(posedge clk); #1 load_start = 0;
        load_valid = 1; load_data = 16'h1111; load_last = 0; model[0] = 16'h1111;
        @(posedge clk); #1 load_data = 16'h2222; model[1] = 16'h2222;
        @(posedge clk); #1 load_valid = 0; rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        checks++;
        if (fetch_busy !== 1'b0 || load_done !== 1'b0 || load_count !== 12'd0 || oob_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_load: busy=%b done=%b count=%0d oob=%b expected 0 0 0 0",
                     fetch_busy, load_done, load_count, oob_err);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1 fetch_req = 1; fetch_addr = 12'(i);
            exp_q.push_back(model[i]);
        end
        @(posedge clk); #1 fetch_req = 0;
    endtask

    initial begin
        test_reset();
        test_program_load();
        test_back_to_back();
        test_collision();
        test_oob_fetch();
        test_load_overflow();
        test_reset_mid_load();
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d fetch results outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_mem_server.md
Name: instr_mem_server

Overview:
- Instruction-memory responder for the fetch stage: serves a 16-bit instruction for each 12-bit fetch address.
- Also has a sequential program-load (writer) port, so a program can be written into memory before or between runs.
- Sits between the fetch unit (driving instr_addr) and the boot/load logic. Replaces the hard-coded test memory in the datapath.

Parameters:
- DEPTH, 256, number of instruction words implemented (max 4096).
- AW, 12, fetch address width; matches instr_addr.
- FILL_WORD, 16'h0000, word returned for addresses >= DEPTH.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- fetch_req  in  1  fetch request strobe
- fetch_addr  in  12  instruction address
- fetch_busy  out  1  high while fetch cannot be accepted (loading)
- instr  out  16  instruction word
- instr_valid  out  1  one-cycle pulse; instr is valid
- load_start  in  1  begin program load at address 0
- load_valid  in  1  load_data is valid this cycle
- load_data  in  16  instruction word to write
- load_last  in  1  marks final word of the load
- load_done  out  1  one-cycle pulse when the load completes
- load_count  out  12  number of words written in the current or last load
- oob_err  out  1  sticky; set by an out-of-range fetch or an overflowing load

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - instr = FILL_WORD; instr_valid = 0; fetch_busy = 0; load_done = 0; load_count = 0; oob_err = 0.
  - FSM goes to IDLE.
  - Memory contents are not cleared.
- FSM state IDLE:
  - fetch_req=1 → registered read; instr and instr_valid appear on the next cycle (latency 1). The state stays IDLE, so back-to-back fetches give one result per cycle.
  - load_start=1 → go to LOAD; the address counter and load_count clear to 0.
- FSM state LOAD:
  - fetch_busy = 1; fetch_req is ignored (no instr_valid).
  - Each load_valid writes load_data to mem[counter], then the counter and load_count increment.
  - load_valid with load_last → write the word, pulse load_done the next cycle, go to DONE.
- FSM state DONE: one cycle; load_done = 1; fetch_busy = 1; then return to IDLE.
- Simultaneous load_start and fetch_req in IDLE: load wins; the fetch is dropped with no instr_valid.
- load_start while in LOAD: the load restarts at address 0 and load_count clears.
- Fetch address >= DEPTH: instr = FILL_WORD, instr_valid still pulses, oob_err sets.
- Load word when counter = DEPTH: the write is discarded, oob_err sets, and load_count saturates at DEPTH. A subsequent load_last still ends the load normally.
- oob_err clears only on rst.
- rst mid-load: the FSM returns to IDLE and the words already written remain in memory.
- Read-during-write is impossible, because fetches are blocked in LOAD and DONE.

Optional Feature:
- Macro: INSTR_PARITY_EN.
- When defined:
  - Each stored word carries an even-parity bit computed at load time.
  - On read, the parity is recomputed and output parity_err (1 bit) pulses with instr_valid on a mismatch.
  - FILL_WORD reads never flag.
- When undefined: there is no parity storage and no parity_err port.

Decomposition:
- Shared package/header:
  - AW and instruction-width constants.
  - FSM state encodings: IDLE=2'd0, LOAD=2'd1, DONE=2'd2.
  - FILL_WORD default.
  - Opcode field position [15:12], shared with the decoder.
- One sub-module, instr_ram: a single-port synchronous RAM (DEPTH x 16, plus the parity bit when enabled) with registered read. The FSM and load counter stay in instr_mem_server.

Test Plan:
1. Program load:
   - Stimulus: rst, then load_start; load 4 words 16'h0208, 16'h0000, 16'h0203, 16'h0209, with load_last on the 4th.
   - Required: load_done pulses 1 cycle after the last word; load_count = 4; fetch_busy is high throughout.
2. Back-to-back fetch:
   - Stimulus: fetch addresses 0,1,2,3 on consecutive cycles.
   - Required: instr = 16'h0208, 16'h0000, 16'h0203, 16'h0209, each 1 cycle after its request, with instr_valid high for 4 consecutive cycles.
3. Collision:
   - Stimulus: fetch_req and load_start in the same cycle.
   - Required: no instr_valid, FSM enters LOAD, fetch_busy = 1 on the next cycle.
4. Out-of-range fetch:
   - Stimulus: fetch addr 12'h100 with DEPTH=256.
   - Required: instr = FILL_WORD, instr_valid = 1, oob_err = 1 and stays set.
5. Load overflow:
   - Stimulus: DEPTH=4; load 6 words, last flagged.
   - Required: load_count = 4, oob_err = 1, load_done pulses, and addr 0 still holds the first word.
6. Reset mid-load:
   - Stimulus: rst asserted after 2 of 4 words.
   - Required: FSM back in IDLE, fetch_busy = 0, and fetches of addr 0 and 1 return the 2 loaded words.
